module_debounce_gray: RTL and testbench

MODULE_DEBOUNCE_GRAY -- requirements
Module: module_debounce_gray

---
 rtl/module_debounce_gray_pkg.sv | 13 +
 rtl/module_debounce_gray_sincronizador.sv | 24 ++
 rtl/module_debounce_gray.sv | 110 +++++++++++
 tb/tb_module_debounce_gray.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/module_debounce_gray_pkg.sv
// rtl/module_debounce_gray_pkg.sv - shared state encodings and timing constants for the Gray debouncer
package module_debounce_gray_pkg;

    // Two-state debouncer: idle on a committed code, or timing a candidate code
    typedef enum logic {
        ESTABLE  = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    // 10 ms of stability at a 27 MHz system clock
    localparam int DEBOUNCE_CYCLES_27MHZ = 270000;

endpackage

// File: rtl/module_debounce_gray_sincronizador.sv
// rtl/module_debounce_gray_sincronizador.sv - two-flop synchronizer for the raw switch bus
module module_sincronizador #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] dato_asinc,
    output logic [WIDTH-1:0] sync_q
);

    logic [WIDTH-1:0] meta_q;

    // First flop may go metastable; only the second flop is visible downstream
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= dato_asinc;
            sync_q <= meta_q;
        end
    end

endmodule

// File: rtl/module_debounce_gray.sv
// rtl/module_debounce_gray.sv - debounces a Gray-coded switch bus and flags multi-bit jumps
module module_debounce_gray
    import module_debounce_gray_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_27MHZ
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] codigo_gray_i,
    output logic [WIDTH-1:0] codigo_gray_o,
    output logic             cambio_o,
    output logic             salto_o,
    output logic             estable_o
);

    // Counter only ever reaches DEBOUNCE_CYCLES-1, so it can never wrap
    localparam int CNT_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;

    estado_t          estado_q,    estado_d;
    logic [WIDTH-1:0] candidato_q, candidato_d;
    logic [CNT_W-1:0] cuenta_q,    cuenta_d;
    logic [WIDTH-1:0] codigo_q,    codigo_d;
    logic             cambio_q,    cambio_d;
    logic             salto_q,     salto_d;

    logic [WIDTH-1:0] diff;
    logic             multi_bit;

    module_sincronizador #(
        .WIDTH (WIDTH)
    ) u_sincronizador (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .dato_asinc (codigo_gray_i),
        .sync_q     (sync_q)
    );

    // More than one bit differs iff clearing the lowest set bit leaves something set
    always_comb begin
        diff      = candidato_q ^ codigo_q;
        multi_bit = |(diff & (diff - WIDTH'(1)));
    end

    // Next-state logic: track a candidate until it has been stable long enough
    always_comb begin
        estado_d    = estado_q;
        candidato_d = candidato_q;
        cuenta_d    = cuenta_q;
        codigo_d    = codigo_q;
        cambio_d    = 1'b0;
        salto_d     = 1'b0;
        case (estado_q)
            ESTABLE: begin
                if (sync_q != codigo_q) begin
                    candidato_d = sync_q;
                    cuenta_d    = '0;
                    estado_d    = CONTANDO;
                end
            end
            CONTANDO: begin
                if (sync_q == codigo_q) begin
                    // Input returned to the committed code: it was a glitch
                    estado_d = ESTABLE;
                end else if (sync_q != candidato_q) begin
                    // Bounced to yet another code: restart the stability window
                    candidato_d = sync_q;
                    cuenta_d    = '0;
                end else if (cuenta_q == CNT_MAX) begin
                    codigo_d = candidato_q;
                    estado_d = ESTABLE;
                    cambio_d = 1'b1;
                    salto_d  = multi_bit;
                end else begin
                    cuenta_d = cuenta_q + CNT_W'(1);
                end
            end
            default: estado_d = ESTABLE;
        endcase
    end

    // State and output registers; strobes are registered alongside the commit
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            estado_q    <= ESTABLE;
            candidato_q <= '0;
            cuenta_q    <= '0;
            codigo_q    <= '0;
            cambio_q    <= 1'b0;
            salto_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            candidato_q <= candidato_d;
            cuenta_q    <= cuenta_d;
            codigo_q    <= codigo_d;
            cambio_q    <= cambio_d;
            salto_q     <= salto_d;
        end
    end

    assign codigo_gray_o = codigo_q;
    assign cambio_o      = cambio_q;
    assign salto_o       = salto_q;
    assign estable_o     = (estado_q == ESTABLE);

endmodule

// File: tb/tb_module_debounce_gray.sv
// tb/tb_module_debounce_gray.sv - scoreboard bench for the Gray debouncer
module tb_module_debounce_gray;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] codigo_gray_i;
    logic [3:0] codigo_gray_o;
    logic       cambio_o;
    logic       salto_o;
    logic       estable_o;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] code;
        logic       salto;
        int         cyc_at;
    } commit_t;

    commit_t exp_q[$];

    module_debounce_gray #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .codigo_gray_i (codigo_gray_i),
        .codigo_gray_o (codigo_gray_o),
        .cambio_o      (cambio_o),
        .salto_o       (salto_o),
        .estable_o     (estable_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_commit(input logic [3:0] code, input logic salto, input int latency);
        commit_t e;
        e.code   = code;
        e.salto  = salto;
        e.cyc_at = cyc + latency;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected commit
    always @(negedge clk) begin
        commit_t e;
        if (cambio_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got cambio_o=1 code=%b expected no strobe (cycle %0d)", codigo_gray_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("commit_code",   int'(codigo_gray_o), int'(e.code));
                check("commit_salto",  int'(salto_o),       int'(e.salto));
                check("commit_cycle",  cyc,                 e.cyc_at);
                check("commit_stable", int'(estable_o),     1);
            end
        end else if (salto_o === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL lone_salto: got salto_o=1 expected 0 without cambio_o (cycle %0d)", cyc);
        end
    end

    initial begin
        rst_i         = 1'b0;
        codigo_gray_i = 4'b1010;
        tick(3);
        check("reset_code",    int'(codigo_gray_o), 0);
        check("reset_cambio",  int'(cambio_o),      0);
        check("reset_salto",   int'(salto_o),       0);
        check("reset_estable", int'(estable_o),     1);

        rst_i         = 1'b1;
        codigo_gray_i = 4'b0000;
        tick(10);
        check("idle_code", int'(codigo_gray_o), 0);

        // Clean single-bit change
        codigo_gray_i = 4'b0001;
        expect_commit(4'b0001, 1'b0, 7);
        tick(6);
        check("clean_before_commit", int'(codigo_gray_o), 0);
        tick(1);
        check("clean_after_commit", int'(codigo_gray_o), 1);
        tick(5);

        // Glitch shorter than the stability window
        codigo_gray_i = 4'b0011;
        tick(3);
        codigo_gray_i = 4'b0001;
        tick(12);
        check("glitch_hold", int'(codigo_gray_o), 1);

        // Bounce between two codes, then settle
        for (int i = 0; i < 5; i++) begin
            codigo_gray_i = (i % 2 == 0) ? 4'b0011 : 4'b0001;
            if (i < 4) tick(2);
        end
        expect_commit(4'b0011, 1'b0, 7);
        tick(12);
        check("bounce_settled", int'(codigo_gray_o), 3);

        // Two-bit jump
        codigo_gray_i = 4'b0110;
        expect_commit(4'b0110, 1'b1, 7);
        tick(12);
        check("jump_code", int'(codigo_gray_o), 6);

        // Reset while counting a candidate
        codigo_gray_i = 4'b0111;
        tick(4);
        check("counting_not_stable", int'(estable_o), 0);
        rst_i         = 1'b0;
        codigo_gray_i = 4'b0110;
        tick(1);
        check("midreset_code",    int'(codigo_gray_o), 0);
        check("midreset_cambio",  int'(cambio_o),      0);
        check("midreset_salto",   int'(salto_o),       0);
        check("midreset_estable", int'(estable_o),     1);
        rst_i = 1'b1;
        expect_commit(4'b0110, 1'b1, 7);
        tick(6);
        check("postreset_before_commit", int'(codigo_gray_o), 0);
        tick(1);
        check("postreset_after_commit", int'(codigo_gray_o), 6);
        tick(8);

        check("pending_commits", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
